// File: rtl/mxu_sequencer.sv
// -----------------------------------------------------------------------------
// mxu_sequencer
//   Drives an N x N output-stationary systolic MXU through one C = A x B
//   (or C += A x B) operation: loads A and B from a word memory, skews them
//   into the west/north feed lanes, drains the MXU pipeline and writes the
//   N*N result words back.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   start, accumulate        operation request (IDLE only), keep accumulators
//   a_addr, b_addr, c_addr   base word addresses (row-major N*N matrices)
//   busy, done               operation in progress / one-cycle completion pulse
//   mem_rd_en/_addr/_data    read port, data returns one cycle after request
//   mem_wr_en/_addr/_data    write port, one word per cycle
//   mxu_ce, mxu_clear        MXU clock enable and accumulator clear
//   north_input, west_input  feed lanes, lane k at [(k+1)*NUM_SIZE-1 : k*NUM_SIZE]
//   mxu_result               C[i][j] at slice i*N+j
//   dbg_state                current FSM state (IDLE=0 .. DONE=5)
//
// Handshake: start is a level sampled only while IDLE; while busy it is
// ignored. done is high for exactly the one DONE cycle, after which the block
// is back in IDLE and may accept start on the following cycle.
// -----------------------------------------------------------------------------
module mxu_sequencer #(
    parameter int NUM_SIZE    = 16,
    parameter int GRID_SIZE   = 2,
    parameter int ADDR_WIDTH  = 5,
    parameter int MXU_LATENCY = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic                              accumulate,
    input  logic [ADDR_WIDTH-1:0]             a_addr,
    input  logic [ADDR_WIDTH-1:0]             b_addr,
    input  logic [ADDR_WIDTH-1:0]             c_addr,
    output logic                              busy,
    output logic                              done,
    output logic                              mem_rd_en,
    output logic [ADDR_WIDTH-1:0]             mem_rd_addr,
    input  logic [NUM_SIZE-1:0]               mem_rd_data,
    output logic                              mem_wr_en,
    output logic [ADDR_WIDTH-1:0]             mem_wr_addr,
    output logic [NUM_SIZE-1:0]               mem_wr_data,
    output logic                              mxu_ce,
    output logic                              mxu_clear,
    output logic [NUM_SIZE*GRID_SIZE-1:0]     north_input,
    output logic [NUM_SIZE*GRID_SIZE-1:0]     west_input,
    input  logic [NUM_SIZE*GRID_SIZE*GRID_SIZE-1:0] mxu_result,
    output logic [2:0]                        dbg_state
);

    localparam int N     = GRID_SIZE;
    localparam int NN    = N * N;
    localparam int SLOTS = 3 * N - 2;
    localparam int CW    = 8;

    localparam logic [CW-1:0] NN_C       = CW'(NN);
    localparam logic [CW-1:0] RD_CNT     = CW'(2 * NN);
    localparam logic [CW-1:0] LOAD_LAST  = CW'(2 * NN);
    localparam logic [CW-1:0] FEED_LAST  = CW'(SLOTS - 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(MXU_LATENCY - 1);
    localparam logic [CW-1:0] WRITE_LAST = CW'(NN - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_FEED  = 3'd2,
        S_DRAIN = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] a_q, b_q, c_q;
    logic                  acc_q;
    logic [NUM_SIZE-1:0]   west_q  [N][SLOTS];
    logic [NUM_SIZE-1:0]   north_q [N][SLOTS];

    // State register, operation context and skew buffers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            acc_q   <= 1'b0;
            for (int i = 0; i < N; i++) begin
                for (int s = 0; s < SLOTS; s++) begin
                    west_q[i][s]  <= '0;
                    north_q[i][s] <= '0;
                end
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == S_IDLE && start) begin
                a_q   <= a_addr;
                b_q   <= b_addr;
                c_q   <= c_addr;
                acc_q <= accumulate;
                // Slots not written during LOAD must feed zeros
                for (int i = 0; i < N; i++) begin
                    for (int s = 0; s < SLOTS; s++) begin
                        west_q[i][s]  <= '0;
                        north_q[i][s] <= '0;
                    end
                end
            end
            // LOAD cycle c receives the word requested in cycle c-1:
            // words 0..NN-1 are A row-major, NN..2NN-1 are B row-major.
            if (state_q == S_LOAD) begin
                for (int r = 0; r < N; r++) begin
                    for (int k = 0; k < N; k++) begin
                        if (cnt_q == CW'(r * N + k + 1))
                            west_q[r][r + k] <= mem_rd_data;
                        if (cnt_q == CW'(NN + k * N + r + 1))
                            north_q[r][r + k] <= mem_rd_data;
                    end
                end
            end
        end
    end

    // Next-state and phase counter
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start)                state_d = S_LOAD;
            S_LOAD:  if (cnt_q == LOAD_LAST)   state_d = S_FEED;
            S_FEED:  if (cnt_q == FEED_LAST)   state_d = S_DRAIN;
            S_DRAIN: if (cnt_q == DRAIN_LAST)  state_d = S_WRITE;
            S_WRITE: if (cnt_q == WRITE_LAST)  state_d = S_DONE;
            S_DONE:                            state_d = S_IDLE;
            default:                           state_d = S_IDLE;
        endcase
        cnt_d = (state_d != state_q || state_q == S_IDLE) ? '0 : cnt_q + 1'b1;
    end

    // Outputs
    always_comb begin
        busy        = (state_q != S_IDLE);
        done        = (state_q == S_DONE);
        mem_rd_en   = 1'b0;
        mem_rd_addr = '0;
        mem_wr_en   = 1'b0;
        mem_wr_addr = '0;
        mem_wr_data = '0;
        mxu_ce      = 1'b0;
        mxu_clear   = 1'b0;
        north_input = '0;
        west_input  = '0;
        dbg_state   = state_q;
        case (state_q)
            S_LOAD: begin
                mxu_clear = (cnt_q == '0) && !acc_q;
                if (cnt_q < RD_CNT) begin
                    mem_rd_en = 1'b1;
                    if (cnt_q < NN_C)
                        mem_rd_addr = a_q + ADDR_WIDTH'(cnt_q);
                    else
                        mem_rd_addr = b_q + ADDR_WIDTH'(cnt_q - NN_C);
                end
            end
            S_FEED: begin
                mxu_ce = 1'b1;
                for (int l = 0; l < N; l++) begin
                    for (int s = 0; s < SLOTS; s++) begin
                        if (cnt_q == CW'(s)) begin
                            west_input[l*NUM_SIZE +: NUM_SIZE]  = west_q[l][s];
                            north_input[l*NUM_SIZE +: NUM_SIZE] = north_q[l][s];
                        end
                    end
                end
            end
            S_DRAIN: mxu_ce = 1'b1;
            S_WRITE: begin
                mem_wr_en   = 1'b1;
                mem_wr_addr = c_q + ADDR_WIDTH'(cnt_q);
                for (int m = 0; m < NN; m++) begin
                    if (cnt_q == CW'(m))
                        mem_wr_data = mxu_result[m*NUM_SIZE +: NUM_SIZE];
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mxu_sequencer.sv
module tb_mxu_sequencer;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- N=2 DUT ----------------
    logic        start = 1'b0, start3 = 1'b0, accumulate = 1'b0;
    logic [4:0]  a_addr = '0, b_addr = '0, c_addr = '0;
    logic        busy, done, mem_rd_en, mem_wr_en, mxu_ce, mxu_clear;
    logic [4:0]  mem_rd_addr, mem_wr_addr;
    logic [15:0] mem_rd_data, mem_wr_data;
    logic [31:0] north_input, west_input;
    logic [63:0] mxu_result;
    logic [2:0]  dbg_state;

    mxu_sequencer #(.NUM_SIZE(16), .GRID_SIZE(2), .ADDR_WIDTH(5), .MXU_LATENCY(1)) dut (
        .clk(clk), .rst(rst), .start(start), .accumulate(accumulate),
        .a_addr(a_addr), .b_addr(b_addr), .c_addr(c_addr),
        .busy(busy), .done(done),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .mxu_ce(mxu_ce), .mxu_clear(mxu_clear),
        .north_input(north_input), .west_input(west_input),
        .mxu_result(mxu_result), .dbg_state(dbg_state)
    );

    // ---------------- N=3 DUT ----------------
    logic         busy3, done3, rd_en3, wr_en3, ce3, clear3;
    logic [4:0]   rd_addr3, wr_addr3;
    logic [15:0]  rd_data3, wr_data3;
    logic [47:0]  north3, west3;
    logic [143:0] result3;
    logic [2:0]   state3;

    mxu_sequencer #(.NUM_SIZE(16), .GRID_SIZE(3), .ADDR_WIDTH(5), .MXU_LATENCY(1)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .accumulate(accumulate),
        .a_addr(a_addr), .b_addr(b_addr), .c_addr(c_addr),
        .busy(busy3), .done(done3),
        .mem_rd_en(rd_en3), .mem_rd_addr(rd_addr3), .mem_rd_data(rd_data3),
        .mem_wr_en(wr_en3), .mem_wr_addr(wr_addr3), .mem_wr_data(wr_data3),
        .mxu_ce(ce3), .mxu_clear(clear3),
        .north_input(north3), .west_input(west3),
        .mxu_result(result3), .dbg_state(state3)
    );

    // ---------------- memory models (1-cycle read latency) ----------------
    logic [15:0] mem  [32];
    logic [15:0] mem3 [32];
    logic        pl_en = 1'b0, pl3_en = 1'b0;
    logic [4:0]  pl_addr = '0;
    logic [15:0] pl_data = '0;

    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
    end

    always @(posedge clk) begin
        if (rd_en3) rd_data3 <= mem3[rd_addr3];
        if (pl3_en) mem3[pl_addr] <= pl_data;
        else if (wr_en3) mem3[wr_addr3] <= wr_data3;
    end

    // ---------------- output-stationary systolic MXU models ----------------
    logic [15:0] h2 [2][2], v2 [2][2], acc2 [2][2];
    always @(posedge clk) begin
        if (mxu_clear) begin
            for (int i = 0; i < 2; i++)
                for (int j = 0; j < 2; j++) begin
                    h2[i][j] <= '0; v2[i][j] <= '0; acc2[i][j] <= '0;
                end
        end else if (mxu_ce) begin
            for (int i = 0; i < 2; i++) begin
                h2[i][0] <= west_input[i*16 +: 16];
                v2[0][i] <= north_input[i*16 +: 16];
                for (int j = 1; j < 2; j++) begin
                    h2[i][j] <= h2[i][j-1];
                    v2[j][i] <= v2[j-1][i];
                end
                for (int j = 0; j < 2; j++) acc2[i][j] <= acc2[i][j] + h2[i][j] * v2[i][j];
            end
        end
    end
    always_comb begin
        mxu_result = '0;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) mxu_result[(i*2+j)*16 +: 16] = acc2[i][j];
    end

    logic [15:0] h3 [3][3], v3 [3][3], acc3 [3][3];
    always @(posedge clk) begin
        if (clear3) begin
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++) begin
                    h3[i][j] <= '0; v3[i][j] <= '0; acc3[i][j] <= '0;
                end
        end else if (ce3) begin
            for (int i = 0; i < 3; i++) begin
                h3[i][0] <= west3[i*16 +: 16];
                v3[0][i] <= north3[i*16 +: 16];
                for (int j = 1; j < 3; j++) begin
                    h3[i][j] <= h3[i][j-1];
                    v3[j][i] <= v3[j-1][i];
                end
                for (int j = 0; j < 3; j++) acc3[i][j] <= acc3[i][j] + h3[i][j] * v3[i][j];
            end
        end
    end
    always_comb begin
        result3 = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) result3[(i*3+j)*16 +: 16] = acc3[i][j];
    end

    // ---------------- monitor (sampled on the falling edge) ----------------
    logic mon_clr = 1'b0;
    int   cyc, done_cnt, done_cyc, clear_cnt, overlap, cyc3, done_cnt3, done_cyc3;
    logic [4:0] rd_q[$];
    logic [4:0] wr_q[$];

    always @(negedge clk) begin
        if (mon_clr) begin
            cyc = 0; done_cnt = 0; done_cyc = 0; clear_cnt = 0; overlap = 0;
            cyc3 = 0; done_cnt3 = 0; done_cyc3 = 0;
            rd_q.delete(); wr_q.delete();
        end else begin
            if (busy) cyc++;
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (mxu_clear) clear_cnt++;
            if (mem_rd_en) rd_q.push_back(mem_rd_addr);
            if (mem_wr_en) wr_q.push_back(mem_wr_addr);
            if (mem_rd_en && mem_wr_en) overlap++;
            if (busy3) cyc3++;
            if (done3) begin done_cnt3++; done_cyc3 = cyc3; end
        end
    end

    // ---------------- driver / checker tasks ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clr_mon();
        @(posedge clk); #1 mon_clr = 1'b1;
        @(posedge clk); #1 mon_clr = 1'b0;
    endtask

    task automatic write_mem(input bit three, input logic [4:0] addr, input logic [15:0] data);
        @(negedge clk); #1;
        pl_addr = addr; pl_data = data;
        if (three) pl3_en = 1'b1; else pl_en = 1'b1;
        @(posedge clk); #1;
        pl_en = 1'b0; pl3_en = 1'b0;
    endtask

    task automatic start_op(input bit three, input logic [4:0] a, input logic [4:0] b,
                            input logic [4:0] c, input logic acc);
        @(negedge clk); #1;
        a_addr = a; b_addr = b; c_addr = c; accumulate = acc;
        if (three) start3 = 1'b1; else start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0; start3 = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        for (int t = 0; t < 200; t++) begin
            @(negedge clk); #1;
            if (cyc == n) return;
        end
        check("wait_cycle_timeout", 0, 1);
    endtask

    task automatic wait_done(input bit three);
        for (int t = 0; t < 300; t++) begin
            @(negedge clk); #1;
            if ((three ? done_cnt3 : done_cnt) > 0) return;
        end
        check("done_timeout", 0, 1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_rd_en"}, 32'(mem_rd_en), 0);
        check({tag, "_wr_en"}, 32'(mem_wr_en), 0);
        check({tag, "_ce"}, 32'(mxu_ce), 0);
        check({tag, "_clear"}, 32'(mxu_clear), 0);
        check({tag, "_rd_addr"}, 32'(mem_rd_addr), 0);
        check({tag, "_wr_addr"}, 32'(mem_wr_addr), 0);
        check({tag, "_wr_data"}, 32'(mem_wr_data), 0);
        check({tag, "_west"}, west_input, 0);
        check({tag, "_north"}, north_input, 0);
        check({tag, "_state"}, 32'(dbg_state), 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [4:0]  a, b, c;
        logic        acc;
        logic [15:0] av[4];
        logic [15:0] bv[4];
        logic [15:0] cv[4];
    } vec_t;

    vec_t vt[4];

    initial begin
        logic [4:0] ea;

        vt[0].a = 5'd0;  vt[0].b = 5'd4;  vt[0].c = 5'd8;  vt[0].acc = 1'b0;
        vt[0].av = '{1, 2, 3, 4}; vt[0].bv = '{5, 6, 7, 8}; vt[0].cv = '{19, 22, 43, 50};
        vt[1].a = 5'd0;  vt[1].b = 5'd4;  vt[1].c = 5'd8;  vt[1].acc = 1'b1;
        vt[1].av = '{1, 2, 3, 4}; vt[1].bv = '{5, 6, 7, 8}; vt[1].cv = '{38, 44, 86, 100};
        vt[2].a = 5'd30; vt[2].b = 5'd4;  vt[2].c = 5'd30; vt[2].acc = 1'b0;
        vt[2].av = '{1, 2, 3, 4}; vt[2].bv = '{5, 6, 7, 8}; vt[2].cv = '{19, 22, 43, 50};
        vt[3].a = 5'd12; vt[3].b = 5'd16; vt[3].c = 5'd20; vt[3].acc = 1'b0;
        vt[3].av = '{2, 0, 1, 3}; vt[3].bv = '{4, 5, 6, 7}; vt[3].cv = '{8, 10, 22, 26};

        // reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check_idle_outputs("reset_active");
        rst = 1'b0;
        @(negedge clk); #1;
        check_idle_outputs("after_reset");

        // table-driven operations
        for (int v = 0; v < 4; v++) begin
            for (int k = 0; k < 4; k++) write_mem(1'b0, vt[v].a + 5'(k), vt[v].av[k]);
            for (int k = 0; k < 4; k++) write_mem(1'b0, vt[v].b + 5'(k), vt[v].bv[k]);
            clr_mon();
            start_op(1'b0, vt[v].a, vt[v].b, vt[v].c, vt[v].acc);
            wait_done(1'b0);
            repeat (3) @(negedge clk);
            #1;
            for (int k = 0; k < 4; k++)
                check($sformatf("vec%0d_c%0d", v, k), 32'(mem[vt[v].c + 5'(k)]), 32'(vt[v].cv[k]));
            check($sformatf("vec%0d_done_cycle", v), done_cyc, 19);
            check($sformatf("vec%0d_done_pulses", v), done_cnt, 1);
            check($sformatf("vec%0d_clear_pulses", v), clear_cnt, vt[v].acc ? 0 : 1);
            check($sformatf("vec%0d_rd_overlap_wr", v), overlap, 0);
            check($sformatf("vec%0d_rd_count", v), rd_q.size(), 8);
            check($sformatf("vec%0d_wr_count", v), wr_q.size(), 4);
            if (rd_q.size() == 8 && wr_q.size() == 4) begin
                for (int k = 0; k < 4; k++) begin
                    ea = vt[v].a + 5'(k);
                    check($sformatf("vec%0d_rd_a%0d", v, k), 32'(rd_q[k]), 32'(ea));
                    ea = vt[v].b + 5'(k);
                    check($sformatf("vec%0d_rd_b%0d", v, k), 32'(rd_q[k+4]), 32'(ea));
                    ea = vt[v].c + 5'(k);
                    check($sformatf("vec%0d_wr%0d", v, k), 32'(wr_q[k]), 32'(ea));
                end
            end
        end

        // start during FEED is ignored
        for (int k = 0; k < 4; k++) write_mem(1'b0, 5'(k), 16'(k + 1));
        for (int k = 0; k < 4; k++) write_mem(1'b0, 5'(k + 4), 16'(k + 5));
        for (int k = 0; k < 4; k++) write_mem(1'b0, 5'(k + 28), 16'hAAAA);
        clr_mon();
        start_op(1'b0, 5'd0, 5'd4, 5'd8, 1'b0);
        wait_cyc(11);
        check("busy_feed_state", 32'(dbg_state), 2);
        a_addr = 5'd20; b_addr = 5'd24; c_addr = 5'd28; accumulate = 1'b1; start = 1'b1;
        @(negedge clk); #1 start = 1'b0;
        wait_done(1'b0);
        repeat (3) @(negedge clk);
        #1;
        check("ign_c0", 32'(mem[8]), 19);
        check("ign_c1", 32'(mem[9]), 22);
        check("ign_c2", 32'(mem[10]), 43);
        check("ign_c3", 32'(mem[11]), 50);
        check("ign_other_c_untouched0", 32'(mem[28]), 32'hAAAA);
        check("ign_other_c_untouched3", 32'(mem[31]), 32'hAAAA);
        check("ign_done_pulses", done_cnt, 1);
        check("ign_done_cycle", done_cyc, 19);
        check("ign_clear_pulses", clear_cnt, 1);
        check("ign_wr_count", wr_q.size(), 4);

        // reset on LOAD cycle 3 aborts
        for (int k = 0; k < 4; k++) write_mem(1'b0, 5'(k + 8), 16'h5555);
        clr_mon();
        start_op(1'b0, 5'd0, 5'd4, 5'd8, 1'b0);
        wait_cyc(3);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk); #1;
        check_idle_outputs("abort");
        repeat (30) @(negedge clk);
        #1;
        check("abort_no_writes", wr_q.size(), 0);
        check("abort_no_done", done_cnt, 0);
        check("abort_mem_kept", 32'(mem[8]), 32'h5555);
        clr_mon();
        start_op(1'b0, 5'd0, 5'd4, 5'd8, 1'b0);
        wait_done(1'b0);
        repeat (3) @(negedge clk);
        #1;
        check("rerun_c0", 32'(mem[8]), 19);
        check("rerun_c1", 32'(mem[9]), 22);
        check("rerun_c2", 32'(mem[10]), 43);
        check("rerun_c3", 32'(mem[11]), 50);
        check("rerun_done_cycle", done_cyc, 19);

        // N=3: identity x [1..9]
        for (int k = 0; k < 9; k++) write_mem(1'b1, 5'(k), (k % 4 == 0) ? 16'd1 : 16'd0);
        for (int k = 0; k < 9; k++) write_mem(1'b1, 5'(k + 9), 16'(k + 1));
        clr_mon();
        start_op(1'b1, 5'd0, 5'd9, 5'd18, 1'b0);
        wait_done(1'b1);
        repeat (3) @(negedge clk);
        #1;
        for (int k = 0; k < 9; k++)
            check($sformatf("n3_c%0d", k), 32'(mem3[5'(k + 18)]), k + 1);
        check("n3_done_cycle", done_cyc3, 37);
        check("n3_done_pulses", done_cnt3, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
